sync_fifo_wr_arbiter: RTL

Round-robin write arbiter that lets N_REQ producers share the single write port of one counter-based synchronous FIFO. It grants one requester at a time for a burst of up to BURST beats, and tags each written word with the requester ID. It honours the FIFO's full flag so that no write is ever dropped.

---
 rtl/sync_fifo_wr_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// sync_fifo_wr_arbiter
//
// Round-robin write arbiter that lets N_REQ producers share the single write
// port of one synchronous FIFO. One requester at a time owns the grant for a
// burst of up to BURST beats. Every word written to the FIFO is tagged with the
// owner's ID in its upper bits. The FIFO full flag is honoured combinationally,
// so a write is never issued into a full FIFO and no beat is ever dropped.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   req_valid   : [N_REQ]        per-requester data valid
//   req_last    : [N_REQ]        per-requester end-of-packet (qualified by valid)
//   req_data    : [N_REQ*WIDTH]  packed payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready   : [N_REQ]        per-requester accept, one-hot or zero
//   fifo_full   : downstream FIFO full flag
//   fifo_wr_en  : FIFO write strobe
//   fifo_din    : [WIDTH+ID_W]   {owner ID, payload}
//   gnt_valid   : a grant is currently held
//   gnt_id      : [ID_W]         current owner; keeps the last owner while idle
// -----------------------------------------------------------------------------
module sync_fifo_wr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    parameter  int BURST = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*WIDTH-1:0]  req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [WIDTH+ID_W-1:0]   fifo_din,
    output logic                    gnt_valid,
    output logic [ID_W-1:0]         gnt_id
);

    localparam int CNT_W = $clog2(BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [ID_W:0]    N_WRAP    = (ID_W + 1)'(N_REQ);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic busy;
    assign busy = (state_q == ST_BUSY);

    // -------------------------------------------------------------------------
    // Owner decode and per-owner signal selection
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] owner_sel;
    logic [WIDTH-1:0] data_masked [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_owner
            assign owner_sel[gi]   = (owner_q == ID_W'(gi));
            // Only the owner is ever offered ready, and only while the FIFO
            // has room; everybody else is back-pressured.
            assign req_ready[gi]   = busy && owner_sel[gi] && !fifo_full;
            assign data_masked[gi] = req_data[gi*WIDTH +: WIDTH] & {WIDTH{owner_sel[gi]}};
        end
    endgenerate

    logic owner_valid;
    logic owner_last;
    logic [WIDTH-1:0] owner_data;

    assign owner_valid = |(req_valid & owner_sel);
    assign owner_last  = |(req_last  & owner_sel);

    // owner_sel is one-hot, so OR-ing the masked payloads is a plain mux.
    always_comb begin
        owner_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            owner_data = owner_data | data_masked[k];
        end
    end

    // -------------------------------------------------------------------------
    // Transfer and release conditions
    // -------------------------------------------------------------------------
    logic xfer;
    logic rel_last;
    logic rel_burst;
    logic rel_drop;
    logic release_grant;

    assign xfer          = busy && owner_valid && !fifo_full;
    assign rel_last      = xfer && owner_last;
    assign rel_burst     = xfer && (beat_cnt_q == LAST_BEAT);
    // An owner that stops presenting data gives up the grant even while the
    // FIFO is full; a full FIFO by itself never forces a release.
    assign rel_drop      = busy && !owner_valid;
    assign release_grant = rel_last || rel_burst || rel_drop;

    // -------------------------------------------------------------------------
    // Rotating-priority search
    //
    // Offset k examines requester (owner + 1 + k) mod N_REQ, so the last slot
    // checked is the current owner itself: it only wins again when nobody
    // else is asking. When the owner released because it dropped valid it is
    // removed from the candidate set explicitly.
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] arb_mask;
    logic [ID_W-1:0]  rot_id    [N_REQ];
    logic [N_REQ-1:0] rot_valid;

    assign arb_mask = rel_drop ? (req_valid & ~owner_sel) : req_valid;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W:0] sum;
            assign sum           = {1'b0, owner_q} + (ID_W + 1)'(gi + 1);
            assign rot_id[gi]    = (sum >= N_WRAP) ? ID_W'(sum - N_WRAP) : sum[ID_W-1:0];
            assign rot_valid[gi] = arb_mask[rot_id[gi]];
        end
    endgenerate

    logic            win_found;
    logic [ID_W-1:0] win_id;

    always_comb begin
        win_found = 1'b0;
        win_id    = owner_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && rot_valid[k]) begin
                win_found = 1'b1;
                win_id    = rot_id[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // One cycle of arbitration latency; nothing is written here.
                if (win_found) begin
                    state_d    = ST_BUSY;
                    owner_d    = win_id;
                    beat_cnt_d = '0;
                end
            end

            ST_BUSY: begin
                if (release_grant) begin
                    // Hand over in the same cycle so back-to-back packets
                    // from different requesters leave no bubble.
                    beat_cnt_d = '0;
                    if (win_found) begin
                        state_d = ST_BUSY;
                        owner_d = win_id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Owner resets to the highest index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= ID_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fifo_wr_en = xfer;
    assign fifo_din   = {owner_q, owner_data};
    assign gnt_valid  = busy;
    assign gnt_id     = owner_q;

endmodule
